// File: rtl/dds_ramp_sequencer.sv
// Frequency-ramp command sequencer for a timestamped DDS command queue.
// Emits N 48-bit frequency writes with linearly stepped frequency and timestamp.
module dds_ramp_sequencer #(
    parameter logic [3:0] CMD_OPCODE = 4'b0001
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [47:0]   start_freq,
    input  logic [47:0]   step_freq,
    input  logic [15:0]   step_count,
    input  logic [63:0]   start_time,
    input  logic [31:0]   interval,
    input  logic          busy,
    output logic          cmd_valid,
    output logic [127:0]  cmd_data,
    output logic          running,
    output logic          done,
    output logic          aborted,
    output logic [15:0]   cmds_sent
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e         state_q;
    logic [47:0]    step_q;
    logic [31:0]    interval_q;
    logic [15:0]    n_q;
    logic [15:0]    cmds_sent_q;
    logic [127:0]   cmd_data_q;
    logic           cmd_valid_q;
    logic           running_q;
    logic           done_q;
    logic           aborted_q;

    logic           xfer_d;
    logic           last_d;
    logic [127:0]   cmd_next_d;

    // The current command word doubles as the frequency/timestamp accumulator.
    always_comb begin
        xfer_d     = cmd_valid_q & ~busy;
        last_d     = (cmds_sent_q == (n_q - 16'd1));
        cmd_next_d = {cmd_data_q[127:64] + {32'h0, interval_q},
                      CMD_OPCODE, 12'h000,
                      cmd_data_q[47:0] + step_q};
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            interval_q  <= '0;
            n_q         <= '0;
            cmds_sent_q <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        step_q      <= step_freq;
                        interval_q  <= interval;
                        n_q         <= step_count;
                        cmds_sent_q <= '0;
                        if (step_count != 16'd0) begin
                            state_q     <= ISSUE;
                            cmd_valid_q <= 1'b1;
                            running_q   <= 1'b1;
                            cmd_data_q  <= {start_time, CMD_OPCODE,
                                            12'h000, start_freq};
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                ISSUE: begin
                    if (xfer_d)
                        cmds_sent_q <= cmds_sent_q + 16'd1;
                    if (abort) begin
                        state_q     <= IDLE;
                        cmd_valid_q <= 1'b0;
                        running_q   <= 1'b0;
                        aborted_q   <= 1'b1;
                    end else if (xfer_d) begin
                        if (last_d) begin
                            state_q     <= FINISH;
                            cmd_valid_q <= 1'b0;
                            running_q   <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            cmd_data_q <= cmd_next_d;
                        end
                    end
                end
                FINISH: begin
                    // A zero-length ramp arrives here without done; pulse it once.
                    if (!done_q)
                        done_q <= 1'b1;
                    else
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign running   = running_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign cmds_sent = cmds_sent_q;

endmodule

// File: tb/tb_dds_ramp_sequencer.sv
// Directed bench for dds_ramp_sequencer.
// Cycle 0 is the cycle in which start is driven high.
module tb_dds_ramp_sequencer;

    logic          CLK100MHZ = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [47:0]   start_freq = '0;
    logic [47:0]   step_freq = '0;
    logic [15:0]   step_count = '0;
    logic [63:0]   start_time = '0;
    logic [31:0]   interval = '0;
    logic          busy = 1'b0;
    logic          cmd_valid;
    logic [127:0]  cmd_data;
    logic          running;
    logic          done;
    logic          aborted;
    logic [15:0]   cmds_sent;

    int vectors = 0;
    int errors  = 0;

    dds_ramp_sequencer #(.CMD_OPCODE(4'b0001)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .start_freq (start_freq),
        .step_freq  (step_freq),
        .step_count (step_count),
        .start_time (start_time),
        .interval   (interval),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .running    (running),
        .done       (done),
        .aborted    (aborted),
        .cmds_sent  (cmds_sent)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    function automatic logic [127:0] word(input logic [63:0] ts,
                                          input logic [47:0] f);
        return {ts, 4'b0001, 12'h000, f};
    endfunction

    task automatic tick;
        @(posedge CLK100MHZ);
        #1;
    endtask

    // Drive a start in cycle 0; returns in cycle 1 with config scrambled.
    task automatic kick(input logic [47:0] sf, input logic [47:0] st,
                        input logic [15:0] n, input logic [63:0] t0,
                        input logic [31:0] iv);
        start_freq = sf;
        step_freq  = st;
        step_count = n;
        start_time = t0;
        interval   = iv;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        start_freq = 48'hDEAD_BEEF_0000;
        step_freq  = 48'h0000_0000_7777;
        step_count = 16'd99;
        start_time = 64'h1234_5678_9ABC_DEF0;
        interval   = 32'h0BAD_F00D;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        step_count = 16'd4;
        tick();
        tick();
        vectors++;
        if ({cmd_valid, running, done, aborted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {cmd_valid, running, done, aborted});
        end
        vectors++;
        if (cmd_data !== 128'h0 || cmds_sent !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 0/0",
                     cmd_data, cmds_sent);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [47:0] f [3];
        logic [63:0] t [3];
        f = '{48'h1000, 48'h1100, 48'h1200};
        t = '{64'd1000, 64'd1050, 64'd1100};
        kick(48'h1000, 48'h100, 16'd3, 64'd1000, 32'd50);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (cmd_valid !== 1'b1 || running !== 1'b1 || done !== 1'b0
                || cmd_data !== word(t[k], f[k])) begin
                errors++;
                $display("FAIL basic_cmd%0d got v=%b r=%b d=%b %h want %h",
                         k, cmd_valid, running, done, cmd_data,
                         word(t[k], f[k]));
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || cmd_valid !== 1'b0 || running !== 1'b0
            || cmds_sent !== 16'd3) begin
            errors++;
            $display("FAIL basic_done got d=%b v=%b r=%b n=%0d want 1 0 0 3",
                     done, cmd_valid, running, cmds_sent);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got d=%b v=%b want 0 0",
                     done, cmd_valid);
        end
    endtask

    task automatic test_busy;
        kick(48'h1000, 48'h100, 16'd3, 64'd1000, 32'd50);
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_data !== word(64'd1000, 48'h1000)) begin
            errors++;
            $display("FAIL busy_cmd0 got %b %h", cmd_valid, cmd_data);
        end
        tick();
        for (int c = 2; c <= 6; c++) begin
            busy = (c <= 5);
            vectors++;
            if (cmd_valid !== 1'b1 || cmds_sent !== 16'd1
                || cmd_data !== word(64'd1050, 48'h1100)) begin
                errors++;
                $display("FAIL busy_hold_c%0d got v=%b n=%0d %h want 1 1 %h",
                         c, cmd_valid, cmds_sent, cmd_data,
                         word(64'd1050, 48'h1100));
            end
            tick();
        end
        busy = 1'b0;
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_data !== word(64'd1100, 48'h1200)
            || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_cmd2 got v=%b d=%b %h", cmd_valid, done,
                     cmd_data);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || cmds_sent !== 16'd3) begin
            errors++;
            $display("FAIL busy_done got d=%b n=%0d want 1 3", done,
                     cmds_sent);
        end
        tick();
    endtask

    task automatic test_back_to_back_neg;
        kick(48'h0, 48'hFFFF_FFFF_FFFF, 16'd2,
             64'hFFFF_FFFF_FFFF_FFF0, 32'h20);
        vectors++;
        if (cmd_valid !== 1'b1
            || cmd_data !== word(64'hFFFF_FFFF_FFFF_FFF0, 48'h0)) begin
            errors++;
            $display("FAIL neg_cmd0 got %b %h", cmd_valid, cmd_data);
        end
        tick();
        vectors++;
        if (cmd_valid !== 1'b1
            || cmd_data !== word(64'h10, 48'hFFFF_FFFF_FFFF)) begin
            errors++;
            $display("FAIL neg_cmd1 got %b %h want %h", cmd_valid, cmd_data,
                     word(64'h10, 48'hFFFF_FFFF_FFFF));
        end
        tick();
        vectors++;
        if (done !== 1'b1 || cmds_sent !== 16'd2) begin
            errors++;
            $display("FAIL neg_done got d=%b n=%0d want 1 2", done, cmds_sent);
        end
        tick();
    endtask

    task automatic test_flat;
        kick(48'h0ABC, 48'h0, 16'd2, 64'd777, 32'd0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_data !== word(64'd777, 48'h0ABC))
            begin
                errors++;
                $display("FAIL flat_cmd%0d got %b %h", k, cmd_valid,
                         cmd_data);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_zero_n;
        kick(48'h1, 48'h1, 16'd0, 64'd5, 32'd5);
        start = 1'b1;
        step_count = 16'd3;
        abort = 1'b1;
        vectors++;
        if (cmd_valid !== 1'b0 || done !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL zero_c1 got v=%b d=%b r=%b want 0 0 0",
                     cmd_valid, done, running);
        end
        tick();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (done !== 1'b1 || cmd_valid !== 1'b0 || cmds_sent !== 16'd0
            || aborted !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got d=%b v=%b n=%0d a=%b want 1 0 0 0",
                     done, cmd_valid, cmds_sent, aborted);
        end
        tick();
        tick();
        vectors++;
        if (done !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_after got d=%b v=%b want 0 0", done,
                     cmd_valid);
        end
    endtask

    task automatic test_abort;
        start = 1'b1;
        abort = 1'b1;
        step_count = 16'd4;
        tick();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (cmd_valid !== 1'b0 || running !== 1'b0 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got v=%b r=%b a=%b want 0 0 0",
                     cmd_valid, running, aborted);
        end
        kick(48'h500, 48'h1, 16'd10, 64'd0, 32'd10);
        for (int c = 1; c <= 4; c++) begin
            start = (c == 2);
            abort = (c == 4);
            vectors++;
            if (cmd_valid !== 1'b1
                || cmd_data !== word(64'(10 * (c - 1)), 48'(12'h500 + c - 1)))
            begin
                errors++;
                $display("FAIL abort_cmd_c%0d got %b %h", c, cmd_valid,
                         cmd_data);
            end
            tick();
        end
        abort = 1'b0;
        vectors++;
        if (aborted !== 1'b1 || cmd_valid !== 1'b0 || running !== 1'b0
            || done !== 1'b0 || cmds_sent !== 16'd4) begin
            errors++;
            $display("FAIL abort_pulse got a=%b v=%b r=%b d=%b n=%0d",
                     aborted, cmd_valid, running, done, cmds_sent);
        end
        for (int c = 6; c <= 8; c++) begin
            tick();
            vectors++;
            if (aborted !== 1'b0 || done !== 1'b0 || cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet_c%0d got a=%b d=%b v=%b", c,
                         aborted, done, cmd_valid);
            end
        end
    endtask

    task automatic test_reset_mid;
        kick(48'h2000, 48'h10, 16'd5, 64'd500, 32'd5);
        tick();
        tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        vectors++;
        if ({cmd_valid, running, done, aborted} !== 4'b0000
            || cmd_data !== 128'h0 || cmds_sent !== 16'h0) begin
            errors++;
            $display("FAIL rstmid got %b %h n=%0d want 0000 0 0",
                     {cmd_valid, running, done, aborted}, cmd_data,
                     cmds_sent);
        end
        kick(48'h3000, 48'h1, 16'd2, 64'd40, 32'd2);
        vectors++;
        if (cmd_valid !== 1'b1 || cmds_sent !== 16'd0
            || cmd_data !== word(64'd40, 48'h3000)) begin
            errors++;
            $display("FAIL rstmid_restart got %b n=%0d %h", cmd_valid,
                     cmds_sent, cmd_data);
        end
        tick();
        tick();
        vectors++;
        if (done !== 1'b1 || cmds_sent !== 16'd2) begin
            errors++;
            $display("FAIL rstmid_done got d=%b n=%0d want 1 2", done,
                     cmds_sent);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_back_to_back_neg();
        test_flat();
        test_zero_n();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dds_ramp_sequencer.md
DDS_RAMP_SEQUENCER -- requirements
Module: dds_ramp_sequencer

Interface
REQ-001 Parameter CMD_OPCODE, default 4'b0001, opcode placed in cmd_data[63:60] (48-bit frequency write).
REQ-002 CLK100MHZ  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  single-cycle request; samples all config inputs.
REQ-005 abort  in  1  terminate ramp.
REQ-006 start_freq  in  48  frequency of command 0.
REQ-007 step_freq  in  48  two's-complement per-command increment.
REQ-008 step_count  in  16  number of commands N.
REQ-009 start_time  in  64  timestamp of command 0.
REQ-010 interval  in  32  unsigned timestamp spacing (clock ticks).
REQ-011 busy  in  1  downstream not ready; transfer = cmd_valid & ~busy at a rising edge.
REQ-012 cmd_valid  out  1  command word valid.
REQ-013 cmd_data  out  128  [127:64] timestamp, [63:60] CMD_OPCODE, [59:48] zero, [47:0] frequency.
REQ-014 running  out  1  high in ISSUE state.
REQ-015 done  out  1  one-cycle pulse after final transfer.
REQ-016 aborted  out  1  one-cycle pulse on abort from ISSUE.
REQ-017 cmds_sent  out  16  transfers completed in current/last ramp.

Function
REQ-018 FSM states IDLE, ISSUE, FINISH; encoding free.
REQ-019 IDLE: start=1, abort=0, N>0 -> latch config, cmds_sent<=0, ISSUE; cmd_valid=1 with command 0 the following cycle.
REQ-020 IDLE: start=1, N=0 -> FINISH, no command issued, cmds_sent<=0.
REQ-021 FINISH: done=1 for exactly one cycle, then IDLE.
REQ-022 Command k: freq_k = start_freq + k*step_freq mod 2^48; ts_k = start_time + k*interval mod 2^64; computed by accumulation, no multiplier.
REQ-023 ISSUE: cmd_valid=1 and cmd_data held stable until transfer; busy=1 stalls indefinitely, no data change.
REQ-024 On transfer of command k<N-1: cmds_sent+1, next cycle presents command k+1 (back-to-back throughput 1 cmd/cycle when busy=0).
REQ-025 On transfer of command N-1: cmds_sent=N, cmd_valid=0 next cycle, state FINISH.
REQ-026 start while in ISSUE or FINISH is ignored; config inputs outside start cycle are ignored.
REQ-027 abort in ISSUE: next cycle cmd_valid=0, aborted=1 one cycle, IDLE, no done; transfer at same edge still counted in cmds_sent.
REQ-028 abort in IDLE or FINISH: no effect on state; aborted stays 0; FINISH still pulses done.
REQ-029 start and abort same cycle in IDLE: abort wins, stay IDLE, no outputs change.
REQ-030 interval=0 legal: all timestamps equal start_time; step_freq=0 legal.
REQ-031 Frequency/timestamp overflow wraps silently, no flag.
REQ-032 cmd_data bits [59:48] always zero; cmd_data may hold last value when cmd_valid=0.

Reset
REQ-033 reset=1: state IDLE; cmd_valid, running, done, aborted =0; cmd_data=0; cmds_sent=0; latched config=0.
REQ-034 reset mid-ramp aborts without done/aborted pulse; reset overrides start and abort.
REQ-035 First start accepted in the cycle after reset deasserts.

Verification
REQ-036 start_freq=0x1000, step=0x100, N=3, start_time=1000, interval=50, busy=0 -> cmd_valid cycles 1-3, freq 0x1000/0x1100/0x1200, ts 1000/1050/1100, opcode 1, done at cycle 4, cmds_sent=3.
REQ-037 Same ramp, busy=1 cycles 2-5 -> command 1 held unchanged cycles 2-6, transferred cycle 6, command 2 at 7, done at 8.
REQ-038 step=48'hFFFF_FFFF_FFFF (-1), start_freq=0, N=2 -> freq 0 then 48'hFFFF_FFFF_FFFF.
REQ-039 N=0 start -> no cmd_valid, done at cycle 2, cmds_sent=0.
REQ-040 N=10, abort at cycle 4 with busy=0 -> cmds_sent=4, aborted pulse cycle 5, cmd_valid=0 from cycle 5, no done; start during run ignored.
REQ-041 reset asserted mid-ramp (N=5, after 2 transfers) -> all outputs 0 next cycle; subsequent start begins at command 0.
